// File: rtl/ram_scan_pkg.sv
// Shared types for the RAM scan streamer: run modes, FSM state codes and the
// word-boundary continuation rule.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_FRAME = 2'd2,
    MODE_LOOP  = 2'd3
  } mode_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  // Decides at a word boundary whether the scanner fetches another word.
  function automatic logic keep_running(input mode_e m, input logic at_last);
    return (m == MODE_LOOP) || ((m == MODE_FRAME) && !at_last);
  endfunction

endpackage

// File: rtl/ram_scan_streamer_key_step_debounce.sv
// Push-button conditioner: two-flop synchroniser, DEB_CYC stable-time filter and
// a one-cycle pulse on each debounced press (falling edge of key_n).
module key_step_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic [1:0]       sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ram_scan_streamer.sv
// Scans RAM window BASE..BASE+LEN-1 and streams the words out with valid/ready.
// Optional CLEAR_ON_READ_EN: each accepted word is overwritten with 0 in an extra write cycle.
module ram_scan_streamer
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int BASE    = 0,
  parameter int LEN     = 1024,
  parameter int DEB_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              key_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              frame_done
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] nxt_idx;
  logic [2:0]        lat_cnt;
  logic              key_press;
  logic              at_last;
  logic              run_on;
  mode_e             mode_q;

  key_step_debounce #(.DEB_CYC(DEB_CYC)) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .press (key_press)
  );

  assign mode_q  = mode_e'(mode);
  assign at_last = (idx == ADDR_W'(LEN - 1));
  assign nxt_idx = at_last ? '0 : idx + ADDR_W'(1);
  assign run_on  = keep_running(mode_q, at_last);

  assign out_valid = (state == S_OUT);
  assign out_sof   = out_valid && (idx == '0);
  assign out_eof   = out_valid && at_last;
  assign busy      = (state != S_IDLE);
  assign ram_wdata = '0;

`ifdef CLEAR_ON_READ_EN
  assign ram_cs    = (state == S_RD) || (state == S_WB);
  assign ram_write = (state == S_WB);
`else
  assign ram_cs    = (state == S_RD);
  assign ram_write = 1'b0;
`endif

  // Address is parked at 0 whenever the RAM is not selected.
  assign ram_addr = ram_cs ? ADDR_W'(BASE) + idx : '0;

`ifdef CLEAR_ON_READ_EN
  logic cont_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      lat_cnt    <= '0;
      out_data   <= '0;
      led        <= '0;
      frame_done <= 1'b0;
`ifdef CLEAR_ON_READ_EN
      cont_q     <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          lat_cnt <= '0;
          if (mode_q == MODE_LOOP || (mode_q == MODE_STEP && key_press)) begin
            state <= S_RD;
          end else if (mode_q == MODE_FRAME && start) begin
            state <= S_RD;
            idx   <= '0;
          end
        end
        // RAM data arrives RD_LAT cycles after the address; capture on the following edge.
        S_RD: begin
          if (lat_cnt == 3'(RD_LAT)) begin
            out_data <= ram_rdata;
            lat_cnt  <= '0;
            state    <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            led        <= out_data;
            frame_done <= at_last && (mode_q == MODE_FRAME || mode_q == MODE_LOOP);
`ifdef CLEAR_ON_READ_EN
            cont_q <= run_on;
            state  <= S_WB;
`else
            idx   <= nxt_idx;
            state <= run_on ? S_RD : S_IDLE;
`endif
          end
        end
`ifdef CLEAR_ON_READ_EN
        S_WB: begin
          idx   <= nxt_idx;
          state <= cont_q ? S_RD : S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_streamer.sv
// Scoreboard bench for ram_scan_streamer with a registered RAM model of RD_LAT cycles.
module tb_ram_scan_streamer;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 2;
  localparam int BASE    = 16'h10;
  localparam int LEN     = 4;
  localparam int DEB_CYC = 8;
`ifdef CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic [15:0] addr;
  } exp_t;

  logic              clk, rst, start, key_n, out_ready;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_cs, ram_write, out_valid, out_sof, out_eof, busy, frame_done;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, out_data, led;

  ram_scan_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .BASE(BASE), .LEN(LEN), .DEB_CYC(DEB_CYC)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .key_n(key_n),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .led(led), .busy(busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: low 4 address bits select the word, data appears RD_LAT cycles later.
  logic [7:0] mem [16];
  logic [7:0] rd_pipe [RD_LAT];
  logic       reload;
  always @(posedge clk) begin
    if (reload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
    end else if (ram_cs && ram_write) begin
      mem[ram_addr[3:0]] <= ram_wdata;
    end
    rd_pipe[0] <= mem[ram_addr[3:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  int   n_chk = 0, n_pass = 0;
  int   acc_cnt = 0, fd_cnt = 0, wr_cnt = 0, exp_idx = 0;
  exp_t sb [$];
  logic cleared [LEN];
  logic [7:0] last_data;
`ifdef CLEAR_ON_READ_EN
  logic [15:0] wq [$];
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Stream and write monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data", 32'(out_data), 32'(e.data));
          check("sof", 32'(out_sof), 32'(e.sof));
          check("eof", 32'(out_eof), 32'(e.eof));
`ifdef CLEAR_ON_READ_EN
          wq.push_back(e.addr);
`endif
        end
      end
      if (frame_done) fd_cnt++;
      if (ram_write) begin
        wr_cnt++;
`ifdef CLEAR_ON_READ_EN
        if (wq.size() == 0) begin
          check("wr_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
        end else begin
          logic [15:0] a;
          a = wq.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(a));
          check("wr_data", 32'(ram_wdata), 32'd0);
          check("wr_cs", 32'(ram_cs), 32'd1);
        end
`else
        check("wr_unexpected", 32'(ram_write), 32'd0);
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word();
    exp_t e;
    int   i;
    i      = exp_idx;
    e.data = cleared[i] ? 8'h00 : 8'hA0 + 8'(i);
    e.sof  = (i == 0);
    e.eof  = (i == LEN - 1);
    e.addr = 16'(BASE + i);
    sb.push_back(e);
    last_data = e.data;
    if (CLR) cleared[i] = 1'b1;
    exp_idx = (exp_idx + 1) % LEN;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    cyc(1);
    reload = 1'b0;
    for (int i = 0; i < LEN; i++) cleared[i] = 1'b0;
  endtask

  task automatic wait_acc(input int target, input string tag);
    for (int n = 0; n < 3000 && acc_cnt < target; n++) @(posedge clk);
    check(tag, 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 200 && busy; n++) @(posedge clk);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic press_key();
    push_word();
    key_n = 1'b0;
    cyc(DEB_CYC + 6);
    key_n = 1'b1;
    cyc(DEB_CYC + 6);
  endtask

  initial begin
    int a0, fd0;
    logic [7:0] held;
    rst = 1'b1; mode = 2'd0; start = 1'b0; key_n = 1'b1; out_ready = 1'b1; reload = 1'b1;
    for (int i = 0; i < LEN; i++) cleared[i] = 1'b0;
    cyc(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(ram_cs), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b0; reload = 1'b0;
    cyc(2);

    // One-shot frame
    a0 = acc_cnt; fd0 = fd_cnt; mode = 2'd2; exp_idx = 0;
    for (int k = 0; k < LEN; k++) push_word();
    pulse_start();
    wait_acc(a0 + 4, "frame_words");
    wait_idle("frame_idle");
    cyc(3);
    check("frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
    check("frame_sb_empty", 32'(sb.size()), 32'd0);

    // Frame with a 10-cycle stall on the third word and a start pulse while busy
    do_reload();
    a0 = acc_cnt; fd0 = fd_cnt; exp_idx = 0;
    for (int k = 0; k < LEN; k++) push_word();
    pulse_start();
    wait_acc(a0 + 2, "bp_first_two");
    #1 out_ready = 1'b0;
    wait_valid("bp_valid_seen");
    held = out_data;
    cyc(2);
    pulse_start();
    cyc(8);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data", 32'(out_data), 32'(held));
    check("bp_no_read", 32'(ram_cs), 32'd0);
    out_ready = 1'b1;
    wait_acc(a0 + 4, "bp_words");
    wait_idle("bp_idle");
    cyc(10);
    check("bp_done_cnt", 32'(fd_cnt - fd0), 32'd1);
    check("bp_no_extra", 32'(acc_cnt - a0), 32'd4);

    // Single-step with a bounce burst shorter than the debounce time
    do_reload();
    a0 = acc_cnt; mode = 2'd1;
    for (int k = 0; k < 3; k++) press_key();
    for (int k = 0; k < 4; k++) begin
      key_n = 1'b0; cyc(3);
      key_n = 1'b1; cyc(3);
    end
    cyc(20);
    check("step_words", 32'(acc_cnt - a0), 32'd3);
    check("step_led", 32'(led), 32'(last_data));
    check("step_sb_empty", 32'(sb.size()), 32'd0);

    // Continuous loop from idx 3, stopped mid word
    do_reload();
    a0 = acc_cnt; fd0 = fd_cnt;
    for (int k = 0; k < 6; k++) push_word();
    mode = 2'd3;
    wait_acc(a0 + 5, "loop_five");
    #1 mode = 2'd0;
    wait_acc(a0 + 6, "loop_six");
    wait_idle("loop_idle");
    cyc(15);
    check("loop_words", 32'(acc_cnt - a0), 32'd6);
    check("loop_wraps", 32'(fd_cnt - fd0), 32'd2);
    check("loop_led", 32'(led), 32'(last_data));
    check("loop_sb_empty", 32'(sb.size()), 32'd0);

    // Re-read the window without reloading RAM
    a0 = acc_cnt; mode = 2'd2; exp_idx = 0;
    for (int k = 0; k < LEN; k++) push_word();
    pulse_start();
    wait_acc(a0 + 4, "reread_words");
    wait_idle("reread_idle");
    cyc(3);

    // Reset while a word is waiting in S_OUT
    do_reload();
    out_ready = 1'b0;
    pulse_start();
    wait_valid("rst_mid_valid_seen");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstm_valid", 32'(out_valid), 32'd0);
    check("rstm_data", 32'(out_data), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_cs", 32'(ram_cs), 32'd0);
    check("rstm_write", 32'(ram_write), 32'd0);
    check("rstm_led", 32'(led), 32'd0);
    check("rstm_sof", 32'(out_sof), 32'd0);
    cyc(2);
    rst = 1'b0; out_ready = 1'b1; mode = 2'd1;
    sb.delete();
`ifdef CLEAR_ON_READ_EN
    wq.delete();
`endif
    a0 = acc_cnt; exp_idx = 0;
    press_key();
    cyc(5);
    check("rstm_step_word", 32'(acc_cnt - a0), 32'd1);
    check("rstm_sb_empty", 32'(sb.size()), 32'd0);
    check("wr_count", 32'(wr_cnt), CLR ? 32'(acc_cnt) : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
